seg_scan: RTL and testbench

Time-multiplexed 4-digit seven-segment display driver with a buffered valid/ready input. It sits directly downstream of the data producer (CPU data bus or counter) and accepts 16-bit hex words only at frame boundaries, so a displayed frame never mixes old and new digits. It decodes each nibble internally, scans the digits with a programmable refresh slot, and inserts dead time between digits to suppress ghosting. It drives the board's DS_A..DS_G and DS_EN1..DS_EN4 pins.

---
 rtl/seg_scan_if.sv | 20 ++
 rtl/seg_scan.sv | 142 ++++++++++++++
 tb/tb_seg_scan.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: valid/ready word channel between a data producer and the
// seg_scan display driver. The producer uses the master modport and the
// display driver uses the slave modport.
interface seg_scan_if;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 4-digit seven-segment driver.
// A 16-bit hex word is buffered in a one-entry pending register and copied
// into the display register only at a frame boundary, so a frame never mixes
// old and new digits. Each digit slot is 2^CLK_DIV_W cycles long and starts
// with BLANK_CYCLES cycles of dead time to suppress ghosting.
// Optional feature: define SEG_SCAN_LZS_EN for leading-zero suppression.
module seg_scan #(
    parameter int CLK_DIV_W    = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    seg_scan_if.slave    bus,
    output logic [6:0]   seg,
    output logic [3:0]   segen
);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    localparam logic [CLK_DIV_W-1:0] BLANK_LAST = CLK_DIV_W'(BLANK_CYCLES - 1);
    localparam logic [CLK_DIV_W-1:0] SLOT_LAST  = {CLK_DIV_W{1'b1}};

    state_t               state;
    logic [CLK_DIV_W-1:0] slot_cnt;
    logic [1:0]           digit;
    logic [15:0]          pending;
    logic [15:0]          disp;
    logic                 pend_full;
    logic                 ready_q;
    logic [3:0]           cur_nib;
    logic                 suppress;
    logic                 frame_end;

    // Hex nibble to a..g segment pattern (bit6 = a, bit0 = g).
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h7B;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;
            4'hD: pat = 7'h3D;
            4'hE: pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

    assign bus.data_ready = ready_q;
    assign frame_end      = (state == DRIVE) && (slot_cnt == SLOT_LAST) && (digit == 2'd3);

    // Select the nibble of the displayed word that belongs to the current digit.
    always_comb begin
        cur_nib = disp[{digit, 2'b00} +: 4];
    end

    // Decide whether the current digit is a leading zero that must stay dark.
    always_comb begin
        suppress = 1'b0;
`ifdef SEG_SCAN_LZS_EN
        case (digit)
            2'd3:    suppress = (disp[15:12] == 4'h0);
            2'd2:    suppress = (disp[15:8]  == 8'h00);
            2'd1:    suppress = (disp[15:4]  == 12'h000);
            default: suppress = 1'b0;
        endcase
`else
        suppress = 1'b0;
`endif
    end

    // Slot timer, digit scan FSM and registered segment/enable outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= BLANK;
            slot_cnt <= '0;
            digit    <= 2'd0;
            seg      <= 7'h00;
            segen    <= 4'h0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            case (state)
                BLANK: begin
                    if (slot_cnt == BLANK_LAST) begin
                        state <= DRIVE;
                        if (suppress) begin
                            seg   <= 7'h00;
                            segen <= 4'h0;
                        end else begin
                            seg   <= decode(cur_nib);
                            segen <= 4'b0001 << digit;
                        end
                    end
                end
                DRIVE: begin
                    if (slot_cnt == SLOT_LAST) begin
                        state <= BLANK;
                        digit <= digit + 1'b1;
                        seg   <= 7'h00;
                        segen <= 4'h0;
                    end
                end
                default: begin
                    state <= BLANK;
                    seg   <= 7'h00;
                    segen <= 4'h0;
                end
            endcase
        end
    end

    // One-entry input buffer; its word moves to the display only at a frame boundary.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending   <= 16'h0000;
            disp      <= 16'h0000;
            pend_full <= 1'b0;
            ready_q   <= 1'b1;
        end else if (frame_end && pend_full) begin
            disp      <= pending;
            pend_full <= 1'b0;
            ready_q   <= 1'b1;
        end else if (bus.data_valid && ready_q) begin
            pending   <= bus.data_in;
            pend_full <= 1'b1;
            ready_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan with P = 16, dead time = 2.
// A reference model tracks cycles since reset, the displayed word and the
// one-entry buffer, and predicts seg/segen/data_ready every cycle.
module tb_seg_scan;

    localparam int W       = 4;
    localparam int BLANK_N = 2;
    localparam int P       = 1 << W;
    localparam int FRAME   = 4 * P;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic       CLK;
    logic       RST_N;
    logic [6:0] seg;
    logic [3:0] segen;

    seg_scan_if bus ();

    seg_scan #(
        .CLK_DIV_W    (W),
        .BLANK_CYCLES (BLANK_N)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus),
        .seg   (seg),
        .segen (segen)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          check_cnt;
    int          pass_cnt;
    int          n;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
    endtask

    task automatic modelReset();
        n      = 0;
        m_disp = 16'h0000;
        m_pend = 16'h0000;
        m_full = 1'b0;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] word);
        bus.data_valid = valid;
        bus.data_in    = word;
    endtask

    task automatic checkOutput();
        int         slot;
        int         d;
        logic [3:0] nib;
        logic [6:0] e_seg;
        logic [3:0] e_en;
        bit         show;
        slot  = n % P;
        d     = (n / P) % 4;
        e_seg = 7'h00;
        e_en  = 4'h0;
        if (slot >= BLANK_N) begin
            nib  = 4'(m_disp >> (4 * d));
            show = 1'b1;
`ifdef SEG_SCAN_LZS_EN
            if (d > 0 && (m_disp >> (4 * d)) == 16'h0000) show = 1'b0;
`endif
            if (show) begin
                e_seg = SEG_TABLE[nib];
                e_en  = 4'(1 << d);
            end
        end
        checkVal("seg", 32'(seg), 32'(e_seg));
        checkVal("segen", 32'(segen), 32'(e_en));
        checkVal("data_ready", 32'(bus.data_ready), 32'(!m_full));
    endtask

    // One clock edge: update the model from the inputs seen at the edge, then check.
    task automatic stepCycle();
        logic        v;
        logic [15:0] w;
        bit          acc;
        v   = bus.data_valid;
        w   = bus.data_in;
        acc = v && !m_full;
        @(posedge CLK);
        if (!RST_N) begin
            modelReset();
        end else begin
            n++;
            if (n % FRAME == 0 && m_full) begin
                m_disp = m_pend;
                m_full = 1'b0;
                acc    = 1'b0;
            end
            if (acc) begin
                m_pend = w;
                m_full = 1'b1;
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic idle(input int cycles);
        applyStimulus(1'b0, 16'($urandom));
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    // Offer a word and keep valid high until it is taken; valid is left high.
    task automatic pushWord(input logic [15:0] word);
        bit done;
        done = 1'b0;
        applyStimulus(1'b1, word);
        for (int i = 0; i < 3 * FRAME && !done; i++) begin
            done = bus.data_valid && bus.data_ready;
            stepCycle();
        end
        checkVal("accept_in_budget", 32'(done), 32'd1);
    endtask

    task automatic waitPhase(input int phase);
        for (int i = 0; i < 2 * FRAME && (n % FRAME) != phase; i++) stepCycle();
        checkVal("phase_reached", 32'(n % FRAME), 32'(phase));
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        modelReset();
        RST_N = 1'b0;
        applyStimulus(1'b0, 16'h0000);

        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) stepCycle();
        RST_N = 1'b1;
        idle(FRAME + 8);

        // Single word, shown from the next frame boundary on.
        pushWord(16'h1234);
        idle(2 * FRAME);

        // Back-pressure: second word waits for the first one's transfer.
        pushWord(16'hAAAA);
        pushWord(16'h5555);
        idle(3 * FRAME);

        // Randomized words with random idle gaps.
        for (int k = 0; k < 6; k++) begin
            pushWord(16'($urandom));
            idle(int'($urandom_range(0, 90)));
        end
        idle(2 * FRAME);

        // Leading-zero case.
        pushWord(16'h0005);
        idle(2 * FRAME + 4);

        // Asynchronous reset during digit 2 while a word is pending.
        waitPhase(1);
        pushWord(16'($urandom) | 16'h8000);
        applyStimulus(1'b0, 16'h0000);
        waitPhase(2 * P + 8);
        #1;
        RST_N = 1'b0;
        #1;
        modelReset();
        checkOutput();
        stepCycle();
        stepCycle();
        RST_N = 1'b1;
        idle(FRAME + 8);

        $display("[TB] finished at model cycle %0d", n);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
